prng_checker: RTL

PRNG_CHECKER -- requirements
Module: prng_checker

---
 rtl/prng_checker_if.sv | 24 ++
 rtl/prng_checker.sv | 119 +++++++++++
 2 files changed

// File: rtl/prng_checker_if.sv
// Observed-PRNG input beat and lock/error status bundle for prng_checker.
interface prng_checker_if #(
   parameter int REG_BITS = 16,
   parameter int ERR_W    = 16
);
   logic                in_valid;
   logic [REG_BITS-1:0] in_data;
   logic [REG_BITS-1:0] seed;
   logic                err_clr;
   logic                locked;
   logic [1:0]          state;
   logic                err_pulse;
   logic [ERR_W-1:0]    err_count;

   modport master (
      output in_valid, in_data, seed, err_clr,
      input  locked, state, err_pulse, err_count
   );

   modport slave (
      input  in_valid, in_data, seed, err_clr,
      output locked, state, err_pulse, err_count
   );
endinterface

// File: rtl/prng_checker.sv
// LFSR sequence checker: hunts for alignment, confirms over LOCK_CNT beats,
// then flywheels its own reference and counts mismatches until lock is lost.
module prng_checker #(
   parameter int REG_BITS    = 16,
   parameter int LOCK_CNT    = 4,
   parameter int LOSS_THRESH = 3,
   parameter int ERR_W       = 16
) (
   input logic           clk,
   input logic           rst_n,
   prng_checker_if.slave bus
);
   localparam int GW = $clog2(LOCK_CNT + 1);
   localparam int BW = $clog2(LOSS_THRESH + 1);

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      CONFIRM = 2'd1,
      LOCKED  = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [REG_BITS-1:0] ref_q, ref_d;
   logic [GW-1:0]       good_q, good_d, good_inc;
   logic [BW-1:0]       bad_q, bad_d, bad_inc;
   logic [ERR_W-1:0]    err_q, err_d;
   logic                pulse_q, pulse_d;
   logic                seed_par, lockup, match, miss;

   function automatic logic [REG_BITS-1:0] nxt(input logic [REG_BITS-1:0] x,
                                               input logic              sp);
      return {x[REG_BITS-2:0], (^x) ^ sp};
   endfunction

   function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
      return (&c) ? c : ERR_W'(c + 1'b1);
   endfunction

   assign seed_par = ^bus.seed;
   // An all-zero word with even seed parity maps onto itself and can never confirm.
   assign lockup   = (bus.in_data == '0) && !seed_par;
   assign match    = (bus.in_data == ref_q);
   assign good_inc = good_q + 1'b1;
   assign bad_inc  = bad_q + 1'b1;

   always_comb begin
      state_d = state_q;
      ref_d   = ref_q;
      good_d  = good_q;
      bad_d   = bad_q;
      pulse_d = 1'b0;
      miss    = 1'b0;
      if (bus.in_valid) begin
         unique case (state_q)
            HUNT: begin
               if (!lockup) begin
                  ref_d   = nxt(bus.in_data, seed_par);
                  good_d  = '0;
                  state_d = CONFIRM;
               end
            end
            CONFIRM: begin
               ref_d = nxt(bus.in_data, seed_par);
               if (match) begin
                  good_d = good_inc;
                  if (good_inc == GW'(LOCK_CNT)) state_d = LOCKED;
               end else begin
                  good_d = '0;
               end
            end
            LOCKED: begin
               ref_d = nxt(ref_q, seed_par);
               if (match) begin
                  bad_d = '0;
               end else begin
                  miss    = 1'b1;
                  pulse_d = 1'b1;
                  if (bad_inc == BW'(LOSS_THRESH)) begin
                     bad_d   = '0;
                     state_d = HUNT;
                  end else begin
                     bad_d = bad_inc;
                  end
               end
            end
            default: state_d = HUNT;
         endcase
      end
   end

   always_comb begin
      err_d = err_q;
      if (bus.err_clr)   err_d = miss ? ERR_W'(1) : '0;
      else if (miss)     err_d = sat_inc(err_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= HUNT;
         ref_q   <= '0;
         good_q  <= '0;
         bad_q   <= '0;
         err_q   <= '0;
         pulse_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ref_q   <= ref_d;
         good_q  <= good_d;
         bad_q   <= bad_d;
         err_q   <= err_d;
         pulse_q <= pulse_d;
      end
   end

   assign bus.locked    = (state_q == LOCKED);
   assign bus.state     = state_q;
   assign bus.err_pulse = pulse_q;
   assign bus.err_count = err_q;
endmodule
